router_pkt_tx: RTL

//  Packet transmitter driving the 1x3 router input port (source end of the router protocol).

---
 rtl/router_pkg.sv | 35 +++
 rtl/router_tx_buf.sv | 25 ++
 rtl/router_pkt_tx.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared types and helpers for the router packet transmitter.
package router_pkg;

  localparam int PKT_DATA_W  = 8;
  localparam int PKT_MAX_LEN = 63;

  localparam logic [1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PARITY,
    ST_GAP
  } state_t;

  // Header byte layout: length in [7:2], destination in [1:0].
  function automatic logic [7:0] make_hdr(input logic [5:0] len, input logic [1:0] addr);
    return {len, addr};
  endfunction

  function automatic logic [5:0] hdr_len(input logic [7:0] hdr);
    return hdr[7:2];
  endfunction

  function automatic logic [1:0] hdr_addr(input logic [7:0] hdr);
    return hdr[1:0];
  endfunction

  function automatic logic [7:0] parity_step(input logic [7:0] par, input logic [7:0] data);
    return par ^ data;
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload byte store: synchronous write, asynchronous read, no reset on the array.
module router_tx_buf
  import router_pkg::*;
#(
  parameter int DATA_W = PKT_DATA_W,
  parameter int DEPTH  = PKT_MAX_LEN + 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/router_pkt_tx.sv
// Source end of the 1x3 router: buffers a payload, then sends header, payload
// and XOR parity onto the router input port while honouring busy.
//
// state   | meaning
// IDLE    | waiting for start; bad config pulses cfg_err
// LOAD    | collecting payload bytes from upstream into the buffer
// HEADER  | header {len,addr} on the wire
// PAYLOAD | payload byte rcnt on the wire
// PARITY  | parity byte on the wire, pkt_valid low
// GAP     | one idle cycle, done pulses
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int DATA_W  = PKT_DATA_W,
  parameter int MAX_LEN = PKT_MAX_LEN,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [1:0]        dest_addr,
  input  logic [LEN_W-1:0]  pay_len,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  input  logic              busy,
  input  logic              err,
  output logic [DATA_W-1:0] data_out,
  output logic              pkt_valid,
  output logic              tx_active,
  output logic              done,
  output logic              cfg_err,
  output logic              pkt_err
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t            state;
  logic [1:0]        addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  wcnt;
  logic [LEN_W-1:0]  rcnt;
  logic [LEN_W-1:0]  raddr;
  logic [DATA_W-1:0] parity_q;
  logic [DATA_W-1:0] rd_data;
  logic              we;
  logic              last_wr;
  logic              last_rd;

  assign we      = (state == ST_LOAD) && src_valid && src_ready;
  assign last_wr = (wcnt == len_q - LEN_ONE);
  assign last_rd = (rcnt == len_q - LEN_ONE);
  // Read address looks one byte ahead so the next byte is ready at the advancing edge.
  assign raddr   = (state == ST_HEADER) ? '0 : rcnt + LEN_ONE;

  router_tx_buf #(
    .DATA_W(DATA_W),
    .DEPTH (MAX_LEN + 1)
  ) u_buf (
    .clock(clock),
    .we   (we),
    .waddr(wcnt),
    .wdata(src_data),
    .raddr(raddr),
    .rdata(rd_data)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      wcnt      <= '0;
      rcnt      <= '0;
      parity_q  <= '0;
      src_ready <= 1'b0;
      data_out  <= '0;
      pkt_valid <= 1'b0;
      tx_active <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      pkt_err   <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      if ((state == ST_PARITY || state == ST_GAP) && err) pkt_err <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start) begin
            if (dest_addr == ADDR_INVALID || pay_len == '0) begin
              cfg_err <= 1'b1;
            end else begin
              addr_q    <= dest_addr;
              len_q     <= pay_len;
              wcnt      <= '0;
              rcnt      <= '0;
              pkt_err   <= 1'b0;
              parity_q  <= DATA_W'(make_hdr(pay_len, dest_addr));
              src_ready <= 1'b1;
              tx_active <= 1'b1;
              state     <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (we) begin
            parity_q <= parity_step(parity_q, src_data);
            wcnt     <= wcnt + LEN_ONE;
            if (last_wr) begin
              src_ready <= 1'b0;
              data_out  <= DATA_W'(make_hdr(len_q, addr_q));
              pkt_valid <= 1'b1;
              state     <= ST_HEADER;
            end
          end
        end
        ST_HEADER: begin
          if (!busy) begin
            data_out <= rd_data;
            rcnt     <= '0;
            state    <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (!busy) begin
            if (last_rd) begin
              data_out  <= parity_q;
              pkt_valid <= 1'b0;
              state     <= ST_PARITY;
            end else begin
              data_out <= rd_data;
              rcnt     <= rcnt + LEN_ONE;
            end
          end
        end
        ST_PARITY: begin
          if (!busy) begin
            data_out <= '0;
            done     <= 1'b1;
            state    <= ST_GAP;
          end
        end
        ST_GAP: begin
          tx_active <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
